timer_counter: RTL and testbench

TIMER_COUNTER -- requirements
Module: timer_counter

---
 rtl/timer_counter_pkg.sv | 31 +++
 rtl/timer_counter.sv | 153 +++++++++++++++
 tb/tb_timer_counter.sv | 362 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/timer_counter_pkg.sv
// Shared timer constants: register word offsets, CTRL bit positions, Mode values
// and FSM state encodings, used by the timer and by CPU-side code.
package timer_counter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } tc_state_e;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_PRESET = 2'd1;
  localparam logic [1:0] ADDR_COUNT  = 2'd2;
  localparam logic [1:0] ADDR_RSVD   = 2'd3;

  localparam int CTRL_W        = 4;
  localparam int CTRL_EN_BIT   = 0;
  localparam int CTRL_MODE_LSB = 1;
  localparam int CTRL_IM_BIT   = 3;

  localparam logic [1:0] MODE_ONESHOT  = 2'd0;
  localparam logic [1:0] MODE_PERIODIC = 2'd1;

  // Observation bundle: current FSM state and the raw (unmasked) interrupt flag.
  typedef struct packed {
    tc_state_e state;
    logic      irq_flag;
  } tc_dbg_t;

endpackage

// File: rtl/timer_counter.sv
// Memory-mapped down-counting timer: CTRL/PRESET/COUNT registers, a four-state
// FSM (IDLE/LOAD/CNT/INT) and a maskable interrupt flag.
module timer_counter
  import timer_counter_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  Addr,
  input  logic        WE,
  input  logic [31:0] Din,
  output logic [31:0] Dout,
  output logic        IRQ,
  output tc_dbg_t     dbg_o
);

  // Bus handshake: a write is a single-cycle WE strobe with Addr/Din valid on the
  // same rising edge; there is no ready/stall, every strobe is accepted.

  tc_state_e          state_q, state_d;
  logic [CTRL_W-1:0]  ctrl_q, ctrl_d;
  logic [31:0]        preset_q, preset_d;
  logic [31:0]        count_q, count_d;
  logic               irq_flag_q, irq_flag_d;

  logic       enable;
  logic [1:0] mode;
  logic       im;
  logic       ctrl_wr;
  logic       preset_wr;

  logic load_count;
  logic dec_count;
  logic zero_count;
  logic irq_set;
  logic irq_clr_auto;
  logic en_clr_auto;

  assign enable    = ctrl_q[CTRL_EN_BIT];
  assign mode      = ctrl_q[CTRL_MODE_LSB +: 2];
  assign im        = ctrl_q[CTRL_IM_BIT];
  assign ctrl_wr   = WE && (Addr == ADDR_CTRL);
  assign preset_wr = WE && (Addr == ADDR_PRESET);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (enable) state_d = ST_LOAD;
      ST_LOAD: state_d = ST_CNT;
      ST_CNT: begin
        if (!enable) begin
          state_d = ST_IDLE;
        end else if (count_q <= 32'd1) begin
          state_d = ST_INT;
        end
      end
      ST_INT: state_d = (mode == MODE_PERIODIC) ? ST_LOAD : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    load_count   = 1'b0;
    dec_count    = 1'b0;
    zero_count   = 1'b0;
    irq_set      = 1'b0;
    irq_clr_auto = 1'b0;
    en_clr_auto  = 1'b0;
    unique case (state_q)
      ST_IDLE: ;
      ST_LOAD: load_count = 1'b1;
      ST_CNT: begin
        if (enable) begin
          // COUNT<=1 covers PRESET=0, which must time out like PRESET=1.
          if (count_q > 32'd1) begin
            dec_count = 1'b1;
          end else begin
            zero_count = 1'b1;
            irq_set    = 1'b1;
          end
        end
      end
      ST_INT: begin
        if (mode == MODE_PERIODIC) begin
          irq_clr_auto = 1'b1;
        end else begin
          en_clr_auto = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    count_d = count_q;
    if (load_count) begin
      count_d = preset_q;
    end else if (dec_count) begin
      count_d = count_q - 32'd1;
    end else if (zero_count) begin
      count_d = 32'd0;
    end

    preset_d = preset_wr ? Din : preset_q;

    // A CPU write to CTRL overrides the one-shot auto-clear of Enable.
    ctrl_d = ctrl_q;
    if (en_clr_auto) ctrl_d[CTRL_EN_BIT] = 1'b0;
    if (ctrl_wr)     ctrl_d = Din[CTRL_W-1:0];

    // A timeout on the same edge as a CTRL write must still be seen.
    irq_flag_d = irq_flag_q;
    if (ctrl_wr || irq_clr_auto) irq_flag_d = 1'b0;
    if (irq_set)                 irq_flag_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_q     <= '0;
      preset_q   <= '0;
      count_q    <= '0;
      irq_flag_q <= 1'b0;
    end else begin
      ctrl_q     <= ctrl_d;
      preset_q   <= preset_d;
      count_q    <= count_d;
      irq_flag_q <= irq_flag_d;
    end
  end

  always_comb begin
    Dout = 32'd0;
    unique case (Addr)
      ADDR_CTRL:   Dout = {{(32-CTRL_W){1'b0}}, ctrl_q};
      ADDR_PRESET: Dout = preset_q;
      ADDR_COUNT:  Dout = count_q;
      ADDR_RSVD:   Dout = 32'd0;
      default:     Dout = 32'd0;
    endcase
  end

  assign IRQ            = im & irq_flag_q;
  assign dbg_o.state    = state_q;
  assign dbg_o.irq_flag = irq_flag_q;

endmodule

// File: tb/tb_timer_counter.sv
// Self-checking bench for timer_counter: directed scenarios plus randomized runs
// checked against a closed-form timeline model of the timer.
module tb_timer_counter;
  import timer_counter_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  Addr;
  logic        WE;
  logic [31:0] Din;
  logic [31:0] Dout;
  logic        IRQ;
  tc_dbg_t     dbg;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] s_ctrl, s_preset, s_count;
  logic        s_irq;
  tc_dbg_t     s_dbg;

  logic [31:0] exp_count_q[$];
  logic [3:0]  exp_ctrl_q[$];
  logic [0:0]  exp_irq_q[$];
  logic [0:0]  exp_flag_q[$];

  timer_counter dut (
    .clk   (clk),
    .reset (reset),
    .Addr  (Addr),
    .WE    (WE),
    .Din   (Din),
    .Dout  (Dout),
    .IRQ   (IRQ),
    .dbg_o (dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  task automatic sample();
    Addr = ADDR_CTRL;   #1 s_ctrl   = Dout;
    Addr = ADDR_PRESET; #1 s_preset = Dout;
    Addr = ADDR_COUNT;  #1 s_count  = Dout;
    s_irq = IRQ;
    s_dbg = dbg;
  endtask

  task automatic step();
    @(negedge clk);
    WE = 1'b0;
    sample();
  endtask

  task automatic arm_write(input logic [1:0] a, input logic [31:0] d);
    WE   = 1'b1;
    Addr = a;
    Din  = d;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  // Start a run: reset, PRESET=n, then CTRL=cv on edge t0; returns just after t0.
  task automatic start_run(input int n, input logic [3:0] cv);
    do_reset();
    arm_write(ADDR_PRESET, 32'(n));
    step();
    arm_write(ADDR_CTRL, {28'd0, cv});
    step();
  endtask

  // ---------------- reference timeline + scoreboard ----------------
  task automatic run_timeline(input string tag, input int n, input logic [3:0] cv,
                              input int kmax);
    int eff, period, j, ec;
    bit periodic, flag, en;
    exp_count_q.delete(); exp_ctrl_q.delete(); exp_irq_q.delete(); exp_flag_q.delete();
    eff      = (n < 1) ? 1 : n;
    period   = eff + 2;
    periodic = (cv[2:1] == MODE_PERIODIC);
    for (int k = 1; k <= kmax; k++) begin
      if (k == 1) begin
        ec = 0; flag = 0; en = 1;
      end else if (!periodic) begin
        j    = k - 2;
        ec   = (n - j > 0) ? n - j : 0;
        flag = (k >= eff + 2);
        en   = (k < eff + 3);
      end else begin
        j    = (k - 2) % period;
        ec   = (n - j > 0) ? n - j : 0;
        flag = (j == eff);
        en   = 1;
      end
      exp_count_q.push_back(32'(ec));
      exp_ctrl_q.push_back({cv[3:1], cv[0] & en});
      exp_flag_q.push_back(flag);
      exp_irq_q.push_back(flag & cv[3]);
    end

    start_run(n, cv);
    for (int k = 1; k <= kmax; k++) begin
      logic [31:0] e_count;
      logic [3:0]  e_ctrl;
      logic [0:0]  e_irq, e_flag;
      step();
      e_count = exp_count_q.pop_front();
      e_ctrl  = exp_ctrl_q.pop_front();
      e_irq   = exp_irq_q.pop_front();
      e_flag  = exp_flag_q.pop_front();
      n_checks++;
      if (s_count !== e_count)
        $display("FAIL %s count k=%0d: got %0d expected %0d", tag, k, s_count, e_count);
      else n_pass++;
      n_checks++;
      if (s_irq !== e_irq[0])
        $display("FAIL %s irq k=%0d: got %b expected %b", tag, k, s_irq, e_irq[0]);
      else n_pass++;
      n_checks++;
      if (s_ctrl !== {28'd0, e_ctrl})
        $display("FAIL %s ctrl k=%0d: got 0x%0h expected 0x%0h", tag, k, s_ctrl, e_ctrl);
      else n_pass++;
      n_checks++;
      if (s_dbg.irq_flag !== e_flag[0])
        $display("FAIL %s irq_flag k=%0d: got %b expected %b", tag, k, s_dbg.irq_flag, e_flag[0]);
      else n_pass++;
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    do_reset();
    n_checks++;
    if (s_ctrl !== 32'd0 || s_preset !== 32'd0 || s_count !== 32'd0)
      $display("FAIL reset_regs: got ctrl=0x%0h preset=0x%0h count=0x%0h expected all 0",
               s_ctrl, s_preset, s_count);
    else n_pass++;
    n_checks++;
    if (s_irq !== 1'b0 || s_dbg.irq_flag !== 1'b0 || s_dbg.state !== ST_IDLE)
      $display("FAIL reset_state: got irq=%b flag=%b state=%0d expected 0/0/IDLE",
               s_irq, s_dbg.irq_flag, s_dbg.state);
    else n_pass++;
  endtask

  task automatic test_regs();
    do_reset();
    arm_write(ADDR_CTRL, 32'hFFFF_FFF0);
    step();
    n_checks++;
    if (s_ctrl !== 32'd0) $display("FAIL ctrl_upper_bits: got 0x%0h expected 0x0", s_ctrl);
    else n_pass++;
    arm_write(ADDR_PRESET, 32'hDEAD_BEEF);
    step();
    n_checks++;
    if (s_preset !== 32'hDEAD_BEEF) $display("FAIL preset_rw: got 0x%0h expected 0xdeadbeef", s_preset);
    else n_pass++;
    arm_write(ADDR_CTRL, 32'h6);
    step();
    n_checks++;
    if (s_ctrl !== 32'h6 || s_dbg.state !== ST_IDLE)
      $display("FAIL ctrl_mode_only: got ctrl=0x%0h state=%0d expected 0x6/IDLE", s_ctrl, s_dbg.state);
    else n_pass++;
    arm_write(ADDR_RSVD, 32'hFFFF_FFFF);
    step();
    Addr = ADDR_RSVD;
    #1;
    n_checks++;
    if (Dout !== 32'd0) $display("FAIL rsvd_read: got 0x%0h expected 0x0", Dout);
    else n_pass++;
  endtask

  task automatic test_ctrl_clear();
    arm_write(ADDR_CTRL, 32'h0);
    step();
    n_checks++;
    if (s_irq !== 1'b0 || s_dbg.irq_flag !== 1'b0)
      $display("FAIL ctrl_clear_irq: got irq=%b flag=%b expected 0/0", s_irq, s_dbg.irq_flag);
    else n_pass++;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++;
      if (s_dbg.state !== ST_IDLE || s_count !== 32'd0)
        $display("FAIL ctrl_clear_idle i=%0d: got state=%0d count=%0d expected IDLE/0",
                 i, s_dbg.state, s_count);
      else n_pass++;
    end
  endtask

  task automatic test_preset_midcount();
    start_run(4, 4'hB);
    for (int k = 1; k <= 4; k++) step();
    n_checks++;
    if (s_count !== 32'd2) $display("FAIL midcount_pre: got %0d expected 2", s_count);
    else n_pass++;
    arm_write(ADDR_PRESET, 32'd10);
    step();
    n_checks++;
    if (s_count !== 32'd1 || s_preset !== 32'd10)
      $display("FAIL midcount_k5: got count=%0d preset=%0d expected 1/10", s_count, s_preset);
    else n_pass++;
    step();
    n_checks++;
    if (s_count !== 32'd0 || s_irq !== 1'b1)
      $display("FAIL midcount_int: got count=%0d irq=%b expected 0/1", s_count, s_irq);
    else n_pass++;
    step();
    n_checks++;
    if (s_irq !== 1'b0 || s_dbg.state !== ST_LOAD)
      $display("FAIL midcount_load: got irq=%b state=%0d expected 0/LOAD", s_irq, s_dbg.state);
    else n_pass++;
    step();
    n_checks++;
    if (s_count !== 32'd10 || s_dbg.state !== ST_CNT)
      $display("FAIL midcount_reload: got count=%0d state=%0d expected 10/CNT", s_count, s_dbg.state);
    else n_pass++;
  endtask

  task automatic test_masked();
    start_run(2, 4'h1);
    for (int k = 1; k <= 4; k++) begin
      step();
      n_checks++;
      if (s_irq !== 1'b0) $display("FAIL masked_irq k=%0d: got %b expected 0", k, s_irq);
      else n_pass++;
    end
    n_checks++;
    if (s_dbg.irq_flag !== 1'b1 || s_count !== 32'd0)
      $display("FAIL masked_flag: got flag=%b count=%0d expected 1/0", s_dbg.irq_flag, s_count);
    else n_pass++;
    arm_write(ADDR_COUNT, 32'h55);
    step();
    n_checks++;
    if (s_count !== 32'd0) $display("FAIL count_readonly: got 0x%0h expected 0x0", s_count);
    else n_pass++;
    arm_write(ADDR_CTRL, 32'h9);
    step();
    n_checks++;
    if (s_dbg.irq_flag !== 1'b0 || s_irq !== 1'b0 || s_ctrl !== 32'h9)
      $display("FAIL masked_unmask: got flag=%b irq=%b ctrl=0x%0h expected 0/0/0x9",
               s_dbg.irq_flag, s_irq, s_ctrl);
    else n_pass++;
    for (int i = 0; i < 2; i++) begin
      step();
      n_checks++;
      if (s_irq !== 1'b0) $display("FAIL masked_after i=%0d: got %b expected 0", i, s_irq);
      else n_pass++;
    end
  endtask

  task automatic test_collisions();
    start_run(2, 4'h9);
    for (int k = 1; k <= 3; k++) step();
    arm_write(ADDR_CTRL, 32'h9);
    step();
    n_checks++;
    if (s_dbg.irq_flag !== 1'b1 || s_irq !== 1'b1 || s_dbg.state !== ST_INT)
      $display("FAIL set_beats_ctrl_write: got flag=%b irq=%b state=%0d expected 1/1/INT",
               s_dbg.irq_flag, s_irq, s_dbg.state);
    else n_pass++;
    arm_write(ADDR_CTRL, 32'h9);
    step();
    n_checks++;
    if (s_ctrl !== 32'h9 || s_dbg.irq_flag !== 1'b0 || s_dbg.state !== ST_IDLE)
      $display("FAIL write_beats_autoclear: got ctrl=0x%0h flag=%b state=%0d expected 0x9/0/IDLE",
               s_ctrl, s_dbg.irq_flag, s_dbg.state);
    else n_pass++;
    step();
    n_checks++;
    if (s_dbg.state !== ST_LOAD) $display("FAIL rearm_load: got state=%0d expected LOAD", s_dbg.state);
    else n_pass++;
  endtask

  task automatic test_reenable();
    start_run(6, 4'h1);
    for (int k = 1; k <= 4; k++) step();
    arm_write(ADDR_CTRL, 32'h0);
    step();
    step();
    n_checks++;
    if (s_count !== 32'd3 || s_dbg.state !== ST_IDLE)
      $display("FAIL pause_hold: got count=%0d state=%0d expected 3/IDLE", s_count, s_dbg.state);
    else n_pass++;
    arm_write(ADDR_CTRL, 32'h1);
    step();
    step();
    n_checks++;
    if (s_dbg.state !== ST_LOAD || s_count !== 32'd3)
      $display("FAIL reenable_load: got state=%0d count=%0d expected LOAD/3", s_dbg.state, s_count);
    else n_pass++;
    step();
    n_checks++;
    if (s_count !== 32'd6) $display("FAIL reenable_reload: got %0d expected 6", s_count);
    else n_pass++;
  endtask

  task automatic test_reset_midcount();
    start_run(9, 4'hB);
    for (int k = 1; k <= 4; k++) step();
    n_checks++;
    if (s_count !== 32'd7) $display("FAIL rst_mid_pre: got %0d expected 7", s_count);
    else n_pass++;
    do_reset();
    n_checks++;
    if (s_ctrl !== 32'd0 || s_preset !== 32'd0 || s_count !== 32'd0 || s_irq !== 1'b0 ||
        s_dbg.state !== ST_IDLE)
      $display("FAIL rst_mid: got ctrl=0x%0h preset=%0d count=%0d irq=%b state=%0d expected 0s/IDLE",
               s_ctrl, s_preset, s_count, s_irq, s_dbg.state);
    else n_pass++;
    start_run(1, 4'h9);
    for (int k = 1; k <= 3; k++) step();
    n_checks++;
    if (s_irq !== 1'b1 || s_dbg.state !== ST_INT)
      $display("FAIL rst_int_pre: got irq=%b state=%0d expected 1/INT", s_irq, s_dbg.state);
    else n_pass++;
    do_reset();
    n_checks++;
    if (s_irq !== 1'b0 || s_dbg.irq_flag !== 1'b0 || s_dbg.state !== ST_IDLE || s_ctrl !== 32'd0)
      $display("FAIL rst_int: got irq=%b flag=%b state=%0d ctrl=0x%0h expected 0/0/IDLE/0",
               s_irq, s_dbg.irq_flag, s_dbg.state, s_ctrl);
    else n_pass++;
  endtask

  task automatic test_random();
    for (int t = 0; t < 6; t++) begin
      int n, eff;
      logic [3:0] cv;
      n   = $urandom_range(0, 10);
      eff = (n < 1) ? 1 : n;
      cv  = {1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'b1};
      run_timeline($sformatf("rand%0d_n%0d_c%0h", t, n, cv), n, cv, 3 * (eff + 2) + 2);
    end
  endtask

  // ---------------- main sequence + report ----------------
  initial begin
    reset = 1'b1;
    WE    = 1'b0;
    Addr  = 2'd0;
    Din   = 32'd0;
    test_reset();
    test_regs();
    run_timeline("oneshot_p5", 5, 4'h9, 12);
    test_ctrl_clear();
    run_timeline("periodic_p3", 3, 4'hB, 22);
    run_timeline("preset_zero", 0, 4'h9, 6);
    run_timeline("preset_one", 1, 4'hB, 10);
    test_preset_midcount();
    test_masked();
    test_collisions();
    test_reenable();
    test_reset_midcount();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
